// File: rtl/tdm_demux.sv
// tdm_demux: TDM serial receiver that splits NCH slots of W bits into per-channel registers.
// Define TDM_DEMUX_STRICT_SYNC_EN to make frame_sync mandatory at every frame boundary.
module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    input  logic             frame_sync,
    output logic [NCH*W-1:0] ch_data,
    output logic [NCH-1:0]   ch_valid,
    output logic             frame_done,
    output logic             locked,
    output logic             sync_err
);
    localparam int BW = $clog2(W);
    localparam int SW = $clog2(NCH);
`ifdef TDM_DEMUX_STRICT_SYNC_EN
    localparam logic STRICT = 1'b1;
`else
    localparam logic STRICT = 1'b0;
`endif

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q;
    logic [BW-1:0]    bit_q;
    logic [SW-1:0]    slot_q;
    logic [W-1:0]     sr_q;
    logic [NCH*W-1:0] data_q;
    logic [NCH-1:0]   valid_q;
    logic             done_q;
    logic             err_q;
    logic [W-1:0]     sr_d;
    logic             boundary;
    logic             last_bit;
    logic             last_slot;

    assign sr_d      = {sr_q[W-2:0], din};
    assign boundary  = (bit_q == '0) && (slot_q == '0);
    assign last_bit  = (bit_q == BW'(W - 1));
    assign last_slot = (slot_q == SW'(NCH - 1));

    // Strobes self-clear every edge; everything else moves only on sample edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bit_q   <= '0;
            slot_q  <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (din_en) begin
                case (state_q)
                    IDLE: begin
                        if (frame_sync) begin
                            sr_q    <= sr_d;
                            bit_q   <= BW'(1);
                            slot_q  <= '0;
                            state_q <= RECV;
                        end
                    end
                    RECV: begin
                        if (frame_sync && !boundary) begin
                            // Misaligned sync: drop the partial slot and restart at slot 0.
                            err_q  <= 1'b1;
                            sr_q   <= sr_d;
                            bit_q  <= BW'(1);
                            slot_q <= '0;
                        end else if (STRICT && boundary && !frame_sync) begin
                            err_q   <= 1'b1;
                            bit_q   <= '0;
                            slot_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            sr_q <= sr_d;
                            if (last_bit) begin
                                data_q[slot_q*W +: W] <= sr_d;
                                valid_q[slot_q]       <= 1'b1;
                                done_q                <= last_slot;
                                bit_q                 <= '0;
                                slot_q                <= last_slot ? '0 : slot_q + 1'b1;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ch_data    = data_q;
    assign ch_valid   = valid_q;
    assign frame_done = done_q;
    assign locked     = (state_q == RECV);
    assign sync_err   = err_q;
endmodule
